// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared types and widths for the uio bus arbiter.
//   arb_state_t : FSM encoding (IDLE=0, TURN=1, OWN=2)
//   DIR_IN/OUT  : requester direction encoding (0 = sample in, 1 = drive out)
//   DATA_W      : pad bus width
//   PTR_W       : round-robin pointer / owner index width (covers NREQ up to 4)
//   CNT_W       : burst counter width (MAX_BURST up to 15)
//   ptr_inc()   : index + 1 modulo n
package uio_arb_pkg;

  localparam int DATA_W = 8;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 4;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } arb_state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
    return (int'(p) >= n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req    in  NREQ   request vector
//   rr_ptr in  PTR_W  index searched first; the search wraps modulo NREQ
//   winner out NREQ   one-hot winner (zero when no request)
//   any    out 1      at least one request present
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  winner,
  output logic             any
);

  // Outer loop walks priority order (offset k from rr_ptr); the inner loop
  // finds the requester sitting at that offset, with wrap-around.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && req[i] &&
            ((int'(rr_ptr) + k == i) || (int'(rr_ptr) + k == i + NREQ))) begin
          winner[i] = 1'b1;
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: shares the 8-bit bidirectional uio pad bus between NREQ
// requesters with round-robin arbitration, bounded bursts and turnaround
// idle cycles whenever the bus direction changes.
//   clk, rst_n   clock, synchronous active-low reset
//   ena          design selected; low behaves as a synchronous idle request
//   req          per-requester level request
//   req_dir      1 = drive out, 0 = sample in (latched at arbitration)
//   req_data     out-data, requester i on bits [8i+7:8i]
//   gnt          one-hot registered grant, high while the requester owns the bus
//   rd_data      registered sample of uio_in, rd_valid qualifies it
//   uio_in       pad input
//   uio_out      pad output data (holds its last value when not driving)
//   uio_oe       pad output enable, all bits equal
//   busy         FSM not idle
//   dbg_state    current FSM state
//
// req/gnt handshake: a requester raises req and holds it until it has been
// served; every cycle in which gnt[i] is high is one owned bus cycle (its
// req_data is captured for uio_out, or uio_in is captured for rd_data).
// Dropping req while granted releases the bus at that clock edge; the cycle
// in which req is seen low is still an owned cycle.
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_dir,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic [DATA_W-1:0]      uio_in,
  output logic [DATA_W-1:0]      uio_out,
  output logic [DATA_W-1:0]      uio_oe,
  output logic                   busy,
  output arb_state_t             dbg_state
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [1:0]       TURN_LAST = 2'(TURNAROUND);

  arb_state_t        state_q, state_d;
  logic [NREQ-1:0]   owner_q, owner_d;      // one-hot latched winner
  logic              dir_q, dir_d;          // latched direction of the winner
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              last_dir_q, last_dir_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [1:0]        turn_q, turn_d;

  logic [NREQ-1:0]   pick_oh;
  logic              pick_any;
  logic [PTR_W-1:0]  pick_idx, owner_idx;
  logic              pick_dir, owner_req, arb;
  logic [DATA_W-1:0] own_data;

  // rr_ptr always points just past the current owner, so searching from it
  // naturally puts the owner last when re-arbitrating at release.
  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (pick_oh),
    .any    (pick_any)
  );

  assign pick_dir  = |(req_dir & pick_oh);
  assign owner_req = |(req & owner_q);

  always_comb begin
    pick_idx  = '0;
    owner_idx = '0;
    own_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
      if (owner_q[i]) begin
        owner_idx = PTR_W'(i);
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    dir_d      = dir_q;
    rr_ptr_d   = rr_ptr_q;
    last_dir_d = last_dir_q;
    burst_d    = burst_q;
    turn_d     = turn_q;
    arb        = 1'b0;

    case (state_q)
      ST_IDLE: arb = 1'b1;
      ST_TURN: begin
        // The winner is committed: it gets OWN even if its req has dropped.
        if (turn_q == TURN_LAST) begin
          state_d    = ST_OWN;
          rr_ptr_d   = ptr_inc(owner_idx, NREQ);
          last_dir_d = dir_q;
          burst_d    = CNT_W'(1);
        end else begin
          turn_d = turn_q + 2'd1;
        end
      end
      ST_OWN: begin
        if (!owner_req || burst_q == BURST_MAX) begin
          arb = 1'b1;
        end else if (burst_q != '1) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (arb) begin
      if (pick_any) begin
        owner_d = pick_oh;
        dir_d   = pick_dir;
        if (TURNAROUND > 0 && pick_dir != last_dir_q) begin
          state_d = ST_TURN;
          turn_d  = 2'd1;
        end else begin
          state_d    = ST_OWN;
          rr_ptr_d   = ptr_inc(pick_idx, NREQ);
          last_dir_d = pick_dir;
          burst_d    = CNT_W'(1);
        end
      end else begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    end
  end

  // Rotation pointer and last direction survive ena=0, only rst_n clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      last_dir_q <= DIR_IN;
    end else if (ena) begin
      rr_ptr_q   <= rr_ptr_d;
      last_dir_q <= last_dir_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      dir_q    <= DIR_IN;
      burst_q  <= '0;
      turn_q   <= '0;
      gnt      <= '0;
      uio_out  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      dir_q    <= dir_d;
      burst_q  <= burst_d;
      turn_q   <= turn_d;
      gnt      <= (state_d == ST_OWN) ? owner_d : '0;
      // Data path acts on the cycle that was owned, one cycle of latency.
      if (state_q == ST_OWN && dir_q == DIR_OUT) uio_out <= own_data;
      rd_valid <= (state_q == ST_OWN && dir_q == DIR_IN);
      if (state_q == ST_OWN && dir_q == DIR_IN) rd_data <= uio_in;
    end
  end

  assign uio_oe    = {DATA_W{state_q == ST_OWN && dir_q == DIR_OUT}};
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
module tb_uio_bus_arbiter;

  localparam int NREQ       = 2;
  localparam int MAX_BURST  = 4;
  localparam int TURNAROUND = 1;
  // expected-word layout: {gnt, uio_oe, busy, rd_valid, rd_data, uio_out, state}
  localparam int EW = NREQ + 8 + 1 + 1 + 8 + 8 + 2;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk;
  logic                 rst_n;
  logic                 ena;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_dir;
  logic [NREQ*8-1:0]    req_data;
  logic [NREQ-1:0]      gnt;
  logic [7:0]           rd_data;
  logic                 rd_valid;
  logic [7:0]           uio_in;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;
  logic                 busy;
  uio_arb_pkg::arb_state_t dbg_state;

  bit         r_drv[NREQ];
  bit         d_dir[NREQ];
  logic [7:0] d_dat[NREQ];

  always_comb begin
    req      = '0;
    req_dir  = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i]             = r_drv[i];
      req_dir[i]         = d_dir[i];
      req_data[i*8 +: 8] = d_dat[i];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uio_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .TURNAROUND(TURNAROUND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .req_dir   (req_dir),
    .req_data  (req_data),
    .gnt       (gnt),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    rd_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  // Bus ownership described as: owner index (-1 = none), remaining turnaround
  // cycles before the owner may use the bus, cycles used in the current burst,
  // and the next requester in rotation order.
  int         m_owner = -1;
  int         m_turn_left = 0;
  int         m_used = 0;
  int         m_next = 0;
  bit         m_last_out = 1'b0;
  bit         m_dir = 1'b0;
  logic [7:0] m_uio_out = '0;
  logic [7:0] m_rd_data = '0;
  bit         m_rd_valid = 1'b0;
  bit         m_served[NREQ];

  always @(posedge clk) begin : ref_model
    bit              owned;
    bit              rel;
    int              w;
    int              st;
    logic [NREQ-1:0] g;
    for (int i = 0; i < NREQ; i++) m_served[i] = 1'b0;
    if (!rst_n || !ena) begin
      m_owner     = -1;
      m_turn_left = 0;
      m_used      = 0;
      m_uio_out   = '0;
      m_rd_data   = '0;
      m_rd_valid  = 1'b0;
      if (!rst_n) begin
        m_next     = 0;
        m_last_out = 1'b0;
      end
    end else begin
      owned      = (m_owner >= 0) && (m_turn_left == 0);
      m_rd_valid = 1'b0;
      if (owned) begin
        m_served[m_owner] = 1'b1;
        if (m_dir) m_uio_out = d_dat[m_owner];
        else begin
          m_rd_valid = 1'b1;
          m_rd_data  = uio_in;
          rd_q.push_back(uio_in);
        end
      end
      rel = (m_owner < 0) || (owned && (!r_drv[m_owner] || m_used == MAX_BURST));
      if (m_owner >= 0 && m_turn_left > 0) begin
        m_turn_left--;
        if (m_turn_left == 0) begin
          m_used     = 1;
          m_next     = (m_owner + 1) % NREQ;
          m_last_out = m_dir;
        end
      end else if (!rel) begin
        m_used++;
      end
      if (rel) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && r_drv[(m_next + k) % NREQ]) w = (m_next + k) % NREQ;
        m_owner = w;
        if (w >= 0) begin
          m_dir = d_dir[w];
          if (TURNAROUND > 0 && m_dir != m_last_out) m_turn_left = TURNAROUND;
          else begin
            m_turn_left = 0;
            m_used      = 1;
            m_next      = (w + 1) % NREQ;
            m_last_out  = m_dir;
          end
        end
      end
    end
    g  = '0;
    st = 0;
    if (m_owner >= 0) begin
      st = (m_turn_left > 0) ? 1 : 2;
      if (m_turn_left == 0) g = NREQ'(1 << m_owner);
    end
    exp_q.push_back({g, (st == 2 && m_dir) ? 8'hFF : 8'h00, st != 0, m_rd_valid,
                     m_rd_data, m_uio_out, 2'(st)});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",       gnt,       e[EW-1 -: NREQ]);
      check("uio_oe",    uio_oe,    e[27:20]);
      check("busy",      busy,      e[19]);
      check("rd_valid",  rd_valid,  e[18]);
      check("rd_data",   rd_data,   e[17:10]);
      check("uio_out",   uio_out,   e[9:2]);
      check("dbg_state", dbg_state, e[1:0]);
    end
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("rd_q_nonempty", 0, 1);
      else check("rd_stream", rd_data, rd_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_drive();
    for (int i = 0; i < NREQ; i++) begin
      r_drv[i] = 1'b0;
      d_dir[i] = 1'b0;
      d_dat[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    idle_drive();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string name, output int cyc);
    cyc = 0;
    while (gnt == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (gnt == '0) begin
      n_checks++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  // ---------------- stimulus ----------------
  int job_left[NREQ];
  int cyc;
  logic [NREQ-1:0] pat;

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'h00;
    idle_drive();
    repeat (2) @(negedge clk);

    // 1: reset values, then a single out request
    check("t1_rst_gnt",  gnt, 0);
    check("t1_rst_oe",   uio_oe, 0);
    check("t1_rst_rdv",  rd_valid, 0);
    check("t1_rst_busy", busy, 0);
    rst_n    = 1'b1;
    r_drv[0] = 1'b1;
    d_dir[0] = 1'b1;
    d_dat[0] = 8'hA5;
    wait_gnt("t1_wait", cyc);
    // reset leaves last_dir = IN, so the first out grant pays the turnaround
    check("t1_latency", cyc, 1 + TURNAROUND);
    check("t1_gnt", gnt, 2'b01);
    check("t1_oe_first", uio_oe, 8'hFF);
    @(negedge clk);
    check("t1_uio_out", uio_out, 8'hA5);
    check("t1_oe", uio_oe, 8'hFF);

    // 2: both requesters out, held: 01 x4, 10 x4, 01 x4 with no gaps
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      r_drv[i] = 1'b1;
      d_dir[i] = 1'b1;
      d_dat[i] = 8'(8'h10 + i);
    end
    wait_gnt("t2_wait", cyc);
    for (int k = 0; k < 12; k++) begin
      pat = ((k / MAX_BURST) % 2 == 0) ? 2'b01 : 2'b10;
      check("t2_rotation", gnt, pat);
      @(negedge clk);
    end

    // 3: out owner then in requester with turnaround
    do_reset();
    uio_in   = 8'h3C;
    r_drv[0] = 1'b1; d_dir[0] = 1'b1; d_dat[0] = 8'h77;
    r_drv[1] = 1'b1; d_dir[1] = 1'b0;
    cyc = 0;
    while (rd_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_rd_valid", rd_valid, 1);
    check("t3_rd_data", rd_data, 8'h3C);

    // 4: owner drops after two owned cycles, nobody else waiting
    do_reset();
    r_drv[0] = 1'b1; d_dir[0] = 1'b1; d_dat[0] = 8'h5A;
    wait_gnt("t4_wait", cyc);
    @(negedge clk);
    r_drv[0] = 1'b0;
    @(negedge clk);
    check("t4_gnt", gnt, 0);
    check("t4_oe", uio_oe, 0);
    check("t4_busy", busy, 0);
    check("t4_uio_out", uio_out, 8'h5A);
    @(negedge clk);
    check("t4_uio_out_hold", uio_out, 8'h5A);

    // 5: reset mid-burst, then both request -> requester 0 first
    do_reset();
    r_drv[0] = 1'b1; d_dir[0] = 1'b1; d_dat[0] = 8'hC3;
    wait_gnt("t5_wait", cyc);
    @(negedge clk);
    rst_n = 1'b0;
    r_drv[1] = 1'b1; d_dir[1] = 1'b1;
    @(negedge clk);
    check("t5_rst_gnt", gnt, 0);
    check("t5_rst_oe", uio_oe, 0);
    check("t5_rst_out", uio_out, 0);
    check("t5_rst_busy", busy, 0);
    rst_n = 1'b1;
    wait_gnt("t5_wait2", cyc);
    check("t5_first", gnt, 2'b01);

    // 6: ena low for one cycle mid-burst keeps the rotation pointer
    do_reset();
    r_drv[0] = 1'b1; d_dir[0] = 1'b1; d_dat[0] = 8'h99;
    wait_gnt("t6_wait", cyc);
    @(negedge clk);
    ena = 1'b0;
    r_drv[1] = 1'b1; d_dir[1] = 1'b1;
    @(negedge clk);
    check("t6_idle_gnt", gnt, 0);
    check("t6_idle_busy", busy, 0);
    ena = 1'b1;
    wait_gnt("t6_wait2", cyc);
    check("t6_next", gnt, 2'b10);

    // random traffic: each requester works through jobs of a random length
    do_reset();
    for (int i = 0; i < NREQ; i++) job_left[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_served[i] && job_left[i] > 0) job_left[i]--;
        if (job_left[i] == 0 && $urandom_range(0, 3) == 0) job_left[i] = $urandom_range(1, 9);
        r_drv[i] = (job_left[i] > 0);
        d_dir[i] = 1'($urandom_range(0, 1));
        d_dat[i] = 8'($urandom);
      end
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 99) != 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    idle_drive();
    repeat (12) @(negedge clk);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
